mem_stage_sram_if: RTL and testbench

- Memory-access stage of the 5-stage LoongArch pipeline.
- Sits between the EX stage and the MEM->WB pipeline register, and owns the sram-like data-memory request/response handshake (req/addr_ok/data_ok).
- Generates size/wstrb/aligned write data and holds the instruction until its response returns.
- Produces mem_ready_go and raw read data for the WB register.
- Drains orphaned responses after an exception/ertn flush.

---
 rtl/mem_stage_sram_if.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_sram_if.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_if.sv
// Memory-access stage of the LoongArch pipeline.
// Latches one instruction from EX, issues at most one sram-like data access
// (req/addr_ok/data_ok), and holds the instruction until its response returns.
// Responses whose instruction was flushed are drained and discarded.
module mem_stage_sram_if #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [1:0]        ex_size,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_has_ex,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_ready_go,
  output logic [31:0]       mem_dram_rdata,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_r;
  logic              mem_valid_r;
  logic              is_load_r;
  logic              is_store_r;
  logic              has_ex_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;

  logic              ready_go_s;
  logic              allowin_s;
  logic              latch_s;
  logic              mem_op_s;
  logic              req_s;
  logic [3:0]        wstrb_s;
  logic [31:0]       lane_wdata_s;
  logic [31:0]       dram_rdata_s;

  // Byte strobes for a store of the given size at the given low address bits.
  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate right-aligned store data across every lane it may land on.
  function automatic logic [31:0] calc_lane_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'd0:    lanes = {4{data[7:0]}};
      2'd1:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Only real, exception-free memory instructions start an access.
  assign mem_op_s = (ex_is_load || ex_is_store) && !ex_has_ex;
  assign latch_s  = ex_to_mem_valid && allowin_s && !flush;

  // Handshake-facing combinational decode of the current state.
  always_comb begin
    ready_go_s   = 1'b0;
    req_s        = 1'b0;
    dram_rdata_s = 32'd0;
    case (state_r)
      S_IDLE: begin
        ready_go_s = mem_valid_r;
      end
      S_REQ: begin
        // Withdrawn in the flush cycle so no acceptance can coincide with flush.
        req_s = !flush;
      end
      S_RESP: begin
        ready_go_s = data_sram_data_ok;
        if (data_sram_data_ok && is_load_r && !has_ex_r) begin
          dram_rdata_s = data_sram_rdata;
        end else begin
          dram_rdata_s = 32'd0;
        end
      end
      S_DRAIN: begin
        ready_go_s = 1'b0;
      end
      default: begin
        ready_go_s = 1'b0;
      end
    endcase
  end

  assign allowin_s = (state_r != S_DRAIN) && (!mem_valid_r || ready_go_s);

  // Request fields come only from latched values so they hold while req is up.
  always_comb begin
    if (is_store_r) begin
      wstrb_s = calc_wstrb(size_r, addr_r[1:0]);
    end else begin
      wstrb_s = 4'b0000;
    end
    lane_wdata_s = calc_lane_wdata(size_r, wdata_r);
  end

  // Instruction latch, valid tracking and access state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      mem_valid_r <= 1'b0;
      is_load_r   <= 1'b0;
      is_store_r  <= 1'b0;
      has_ex_r    <= 1'b0;
      size_r      <= 2'd0;
      addr_r      <= '0;
      wdata_r     <= 32'd0;
    end else if (flush) begin
      mem_valid_r <= 1'b0;
      case (state_r)
        S_REQ:   state_r <= S_IDLE;
        S_RESP:  state_r <= data_sram_data_ok ? S_IDLE : S_DRAIN;
        S_DRAIN: state_r <= data_sram_data_ok ? S_IDLE : S_DRAIN;
        default: state_r <= S_IDLE;
      endcase
    end else if (latch_s) begin
      mem_valid_r <= 1'b1;
      is_load_r   <= ex_is_load;
      is_store_r  <= ex_is_store;
      has_ex_r    <= ex_has_ex;
      size_r      <= ex_size;
      addr_r      <= ex_addr;
      wdata_r     <= ex_wdata;
      state_r     <= mem_op_s ? S_REQ : S_IDLE;
    end else begin
      if (allowin_s && !ex_to_mem_valid) begin
        mem_valid_r <= 1'b0;
      end
      case (state_r)
        S_IDLE:  state_r <= S_IDLE;
        S_REQ:   state_r <= (req_s && data_sram_addr_ok) ? S_RESP : S_REQ;
        S_RESP:  state_r <= data_sram_data_ok ? S_IDLE : S_RESP;
        S_DRAIN: state_r <= data_sram_data_ok ? S_IDLE : S_DRAIN;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign mem_allowin     = allowin_s;
  assign mem_valid       = mem_valid_r;
  assign mem_ready_go    = ready_go_s;
  assign mem_dram_rdata  = dram_rdata_s;
  assign data_sram_req   = req_s;
  assign data_sram_wr    = is_store_r;
  assign data_sram_size  = size_r;
  assign data_sram_wstrb = wstrb_s;
  assign data_sram_addr  = addr_r;
  assign data_sram_wdata = lane_wdata_s;

endmodule

// File: tb/tb_mem_stage_sram_if.sv
// Self-checking bench for mem_stage_sram_if: directed scenarios plus
// randomized accesses checked against a transaction-level expectation model.
module tb_mem_stage_sram_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_to_mem_valid;
  logic        mem_allowin;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_has_ex;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready_go;
  logic [31:0] mem_dram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int errors = 0;
  int checks = 0;

  mem_stage_sram_if #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_size(ex_size),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_has_ex(ex_has_ex),
    .flush(flush), .mem_valid(mem_valid), .mem_ready_go(mem_ready_go),
    .mem_dram_rdata(mem_dram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  // Model: a store of 2^size bytes covers the naturally aligned byte lanes holding addr.
  function automatic logic [3:0] exp_wstrb(input logic st, input logic [1:0] sz, input logic [31:0] ad);
    int nbytes;
    int lane;
    if (!st) return 4'd0;
    nbytes = 1 << sz;
    lane   = (int'(ad % 4) / nbytes) * nbytes;
    return 4'(((1 << nbytes) - 1) << lane);
  endfunction

  // Model: the low 2^size bytes of data repeated in every slot of that width.
  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int nbits;
    logic [31:0] unit;
    logic [31:0] res;
    nbits = 8 * (1 << sz);
    unit  = (nbits == 32) ? wd : (wd & ((32'd1 << nbits) - 32'd1));
    res   = 32'd0;
    for (int k = 0; k < 32 / nbits; k++) res = res | (unit << (k * nbits));
    return res;
  endfunction

  task automatic idle_inputs();
    ex_to_mem_valid   = 1'b0;
    ex_is_load        = 1'b0;
    ex_is_store       = 1'b0;
    ex_size           = 2'd0;
    ex_addr           = 32'd0;
    ex_wdata          = 32'd0;
    ex_has_ex         = 1'b0;
    flush             = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
  endtask

  task automatic present(input logic ld, input logic st, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd, input logic hx);
    ex_to_mem_valid = 1'b1;
    ex_is_load = ld; ex_is_store = st; ex_size = sz;
    ex_addr = ad; ex_wdata = wd; ex_has_ex = hx;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({mem_valid, data_sram_req, mem_ready_go, mem_dram_rdata, mem_allowin} !== {1'b0, 1'b0, 1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b req=%b rg=%b rd=%h aw=%b, expected 0 0 0 0 1",
               mem_valid, data_sram_req, mem_ready_go, mem_dram_rdata, mem_allowin);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({mem_valid, data_sram_req, data_sram_wstrb} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_idle: got v=%b req=%b wstrb=%b", mem_valid, data_sram_req, data_sram_wstrb);
    end
  endtask

  // One access with addr_ok after aok_dly stall cycles and data_ok after dok_dly.
  task automatic test_access(input logic ld, input logic st, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                             input int aok_dly, input int dok_dly);
    logic [3:0]  ew;
    logic [31:0] ewd;
    logic        last;
    ew  = exp_wstrb(st, sz, ad);
    ewd = exp_wdata(sz, wd);
    @(negedge clk);
    present(ld, st, sz, ad, wd, 1'b0);
    #1;
    checks++;
    if (mem_allowin !== 1'b1) begin
      errors++; $display("FAIL access_allowin_at_latch: got %b expected 1", mem_allowin);
    end
    for (int i = 0; i <= aok_dly; i++) begin
      @(negedge clk);
      ex_to_mem_valid = 1'b0;
      ex_addr = $urandom; ex_wdata = $urandom; ex_size = 2'($urandom);
      data_sram_addr_ok = (i == aok_dly);
      data_sram_rdata = $urandom;
      #1;
      checks++;
      if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
           mem_ready_go, mem_allowin, mem_valid} !== {1'b1, st, sz, ad, ew, ewd, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL access_req_fields(cyc %0d): got req=%b wr=%b sz=%0d addr=%h strb=%b wd=%h rg=%b aw=%b v=%b, expected 1 %b %0d %h %b %h 0 0 1",
                 i, data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb,
                 data_sram_wdata, mem_ready_go, mem_allowin, mem_valid, st, sz, ad, ew, ewd);
      end
    end
    for (int i = 0; i <= dok_dly; i++) begin
      last = (i == dok_dly);
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = last;
      data_sram_rdata = last ? rd : $urandom;
      #1;
      checks++;
      if ({data_sram_req, mem_ready_go, mem_allowin, mem_dram_rdata} !==
          {1'b0, last, last, ((last && ld) ? rd : 32'd0)}) begin
        errors++;
        $display("FAIL access_resp(cyc %0d): got req=%b rg=%b aw=%b rd=%h, expected 0 %b %b %h",
                 i, data_sram_req, mem_ready_go, mem_allowin, mem_dram_rdata, last, last,
                 (last && ld) ? rd : 32'd0);
      end
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    checks++;
    if ({mem_valid, mem_ready_go, data_sram_req} !== 3'b000) begin
      errors++;
      $display("FAIL access_done_idle: got v=%b rg=%b req=%b expected 000", mem_valid, mem_ready_go, data_sram_req);
    end
  endtask

  task automatic test_has_ex();
    @(negedge clk);
    present(1'b1, 1'b0, 2'd2, 32'h1C000020, 32'd0, 1'b1);
    #1;
    checks++;
    if (data_sram_req !== 1'b0) begin
      errors++; $display("FAIL has_ex_req_at_latch: got %b expected 0", data_sram_req);
    end
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_data_ok = 1'b1;          // stray response must be ignored
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if ({data_sram_req, mem_valid, mem_ready_go, mem_allowin, mem_dram_rdata} !== {4'b0111, 32'd0}) begin
      errors++;
      $display("FAIL has_ex_complete: got req=%b v=%b rg=%b aw=%b rd=%h, expected 0 1 1 1 0",
               data_sram_req, mem_valid, mem_ready_go, mem_allowin, mem_dram_rdata);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    checks++;
    if ({mem_valid, data_sram_req} !== 2'b00) begin
      errors++; $display("FAIL has_ex_retire: got v=%b req=%b expected 00", mem_valid, data_sram_req);
    end
  endtask

  // New store latches in the same cycle the preceding load's data_ok arrives.
  task automatic test_back_to_back();
    @(negedge clk);
    present(1'b1, 1'b0, 2'd2, 32'h00002000, 32'd0, 1'b0);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11223344;
    present(1'b0, 1'b1, 2'd0, 32'h00003001, 32'h000000C3, 1'b0);
    #1;
    checks++;
    if ({mem_ready_go, mem_allowin, mem_dram_rdata} !== {2'b11, 32'h11223344}) begin
      errors++;
      $display("FAIL b2b_first_done: got rg=%b aw=%b rd=%h expected 1 1 11223344",
               mem_ready_go, mem_allowin, mem_dram_rdata);
    end
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_addr_ok = 1'b1;
    #1;
    checks++;
    if ({data_sram_req, data_sram_wr, data_sram_addr, data_sram_wstrb, data_sram_wdata, mem_valid} !==
        {2'b11, 32'h00003001, 4'b0010, 32'hC3C3C3C3, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second_req: got req=%b wr=%b addr=%h strb=%b wd=%h v=%b",
               data_sram_req, data_sram_wr, data_sram_addr, data_sram_wstrb, data_sram_wdata, mem_valid);
    end
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    #1;
    checks++;
    if ({mem_ready_go, mem_dram_rdata} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL b2b_second_done: got rg=%b rd=%h expected 1 0", mem_ready_go, mem_dram_rdata);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_resp();
    @(negedge clk);
    present(1'b1, 1'b0, 2'd2, 32'h1C000100, 32'd0, 1'b0);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);                     // RESP, flush arrives before data_ok
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    present(1'b1, 1'b0, 2'd2, 32'h1C000200, 32'd0, 1'b0);
    #1;
    checks++;
    if ({mem_ready_go, data_sram_req} !== 2'b00) begin
      errors++; $display("FAIL flush_resp_cycle: got rg=%b req=%b expected 00", mem_ready_go, data_sram_req);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      flush = 1'b0;
      data_sram_data_ok = (i == 3);
      data_sram_rdata = 32'hBADBAD00 + 32'(i);
      #1;
      checks++;
      if ({mem_valid, mem_allowin, data_sram_req, mem_ready_go, mem_dram_rdata} !== {4'b0000, 32'd0}) begin
        errors++;
        $display("FAIL flush_drain(cyc %0d): got v=%b aw=%b req=%b rg=%b rd=%h expected all 0",
                 i, mem_valid, mem_allowin, data_sram_req, mem_ready_go, mem_dram_rdata);
      end
    end
    @(negedge clk);                     // back in IDLE, pending load may latch
    data_sram_data_ok = 1'b0;
    #1;
    checks++;
    if ({mem_allowin, data_sram_req} !== 2'b10) begin
      errors++; $display("FAIL flush_after_drain: got aw=%b req=%b expected 10", mem_allowin, data_sram_req);
    end
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    #1;
    checks++;
    if ({data_sram_req, data_sram_addr, data_sram_wr} !== {1'b1, 32'h1C000200, 1'b0}) begin
      errors++; $display("FAIL flush_next_load_req: got req=%b addr=%h wr=%b", data_sram_req, data_sram_addr, data_sram_wr);
    end
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5A5A0001;
    #1;
    checks++;
    if ({mem_ready_go, mem_dram_rdata} !== {1'b1, 32'h5A5A0001}) begin
      errors++; $display("FAIL flush_next_load_data: got rg=%b rd=%h expected 1 5a5a0001", mem_ready_go, mem_dram_rdata);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_req();
    @(negedge clk);
    present(1'b0, 1'b1, 2'd2, 32'h00004000, 32'h87654321, 1'b0);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (data_sram_req !== 1'b1) begin
      errors++; $display("FAIL flush_req_pre: got req=%b expected 1", data_sram_req);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (data_sram_req !== 1'b0) begin
      errors++; $display("FAIL flush_req_withdrawn: got req=%b expected 0", data_sram_req);
    end
    @(negedge clk);
    flush = 1'b0;
    data_sram_addr_ok = 1'b1;
    #1;
    checks++;
    if ({data_sram_req, mem_valid, mem_allowin, mem_ready_go} !== 4'b0010) begin
      errors++;
      $display("FAIL flush_req_idle: got req=%b v=%b aw=%b rg=%b expected 0 0 1 0",
               data_sram_req, mem_valid, mem_allowin, mem_ready_go);
    end
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    present(1'b1, 1'b0, 2'd2, 32'h00005000, 32'd0, 1'b0);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BADF00D;
    #1;
    checks++;
    if ({mem_valid, mem_allowin, data_sram_req, mem_ready_go, mem_dram_rdata} !== {4'b0100, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_access: got v=%b aw=%b req=%b rg=%b rd=%h expected 0 1 0 0 0",
               mem_valid, mem_allowin, data_sram_req, mem_ready_go, mem_dram_rdata);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_random();
    logic        ld;
    logic [1:0]  sz;
    logic [31:0] ad;
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom);
      sz = 2'($urandom_range(0, 2));
      ad = $urandom & ~((32'd1 << sz) - 32'd1);
      test_access(ld, !ld, sz, ad, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_access(1'b1, 1'b0, 2'd2, 32'h1C000010, 32'd0, 32'hDEADBEEF, 0, 0);
    test_access(1'b0, 1'b1, 2'd0, 32'h00001003, 32'h000000A5, 32'h0, 0, 2);
    test_access(1'b0, 1'b1, 2'd1, 32'h00001002, 32'h00001234, 32'h0, 0, 0);
    test_access(1'b0, 1'b1, 2'd2, 32'h00001008, 32'h89ABCDEF, 32'h0, 3, 0);
    test_access(1'b1, 1'b0, 2'd0, 32'h00001001, 32'd0, 32'h01020304, 3, 1);
    test_has_ex();
    test_back_to_back();
    test_flush_resp();
    test_flush_req();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
